// File: rtl/sm83_pkg.sv
`default_nettype none
// ============================================================================
// sm83_pkg : address map constants, region/DMA types and the region decoder
// Revision : 1.0
// ============================================================================
package sm83_pkg;

  localparam logic [15:0] ADDR_DMA      = 16'hFF46;
  localparam logic [15:0] ADDR_BOOT_OFF = 16'hFF50;
  localparam logic [15:0] ADDR_IE       = 16'hFFFF;

  typedef enum logic [3:0] {
    BOOT, CART, WRAM, HRAM, IE, DMAREG, OAM, BOOTOFF, NONE
  } mem_region_t;

  typedef enum logic [1:0] {
    DMA_IDLE, DMA_START, DMA_XFER
  } dma_state_t;

  // Writes decode with boot_en=0 so the low page always reaches the cartridge.
  function automatic mem_region_t decode_region(input logic [15:0] addr,
                                                input logic        boot_en);
    mem_region_t region;
    if (boot_en && addr[15:8] == 8'h00)
      region = BOOT;
    else if (!addr[15] || addr[15:13] == 3'b101)
      region = CART;
    else if (addr >= 16'hC000 && addr <= 16'hFDFF)
      region = WRAM;
    else if (addr >= 16'hFE00 && addr <= 16'hFE9F)
      region = OAM;
    else if (addr == ADDR_DMA)
      region = DMAREG;
    else if (addr == ADDR_BOOT_OFF)
      region = BOOTOFF;
    else if (addr == ADDR_IE)
      region = IE;
    else if (addr >= 16'hFF80)
      region = HRAM;
    else
      region = NONE;
    return region;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm83_bus_responder_if.sv
`default_nettype none
// ============================================================================
// sm83_bus_responder_if : core-side read/write memory bus
// Revision : 1.0
// ============================================================================
interface sm83_bus_responder_if;
  logic [15:0] r_addr;
  logic [7:0]  r_data;
  logic [15:0] w_addr;
  logic [7:0]  w_data;
  logic        w_wen;

  modport master (output r_addr, w_addr, w_data, w_wen, input r_data);
  modport slave  (input r_addr, w_addr, w_data, w_wen, output r_data);
endinterface
`default_nettype wire

// File: rtl/sm83_oam_dma.sv
`default_nettype none
// ============================================================================
// sm83_oam_dma : OAM DMA engine - FSM, byte counter, source page and OAM port
// Revision : 1.0
// ============================================================================
module sm83_oam_dma
  import sm83_pkg::*;
#(
  parameter int OAM_LEN = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  start_val,
  input  logic [7:0]  rd_data,
  output logic [15:0] rd_addr,
  output logic        rd_en,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_wen,
  output logic        active
);

  localparam int              CNT_W    = $clog2(OAM_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OAM_LEN);

  dma_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       src_hi;
  logic [7:0]       fetched;

  always_ff @(posedge clk) begin
    if (rst) state <= DMA_IDLE;
    else     state <= state_nxt;
  end

  // Source pages E0..FF alias back into WRAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      src_hi  <= 8'h00;
      fetched <= 8'h00;
    end else begin
      fetched <= rd_data;
      if (start) begin
        src_hi <= (start_val < 8'hE0) ? start_val : (start_val & 8'hDF);
        cnt    <= '0;
      end else if (state == DMA_XFER) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    oam_wen   = 1'b0;
    active    = 1'b0;
    rd_addr   = {src_hi, 8'(cnt)};
    oam_addr  = 8'(cnt - 1'b1);
    oam_wdata = fetched;
    case (state)
      DMA_START: begin
        active    = 1'b1;
        state_nxt = DMA_XFER;
      end
      DMA_XFER: begin
        active  = 1'b1;
        rd_en   = (cnt != CNT_LAST);
        oam_wen = (cnt != '0);
        if (cnt == CNT_LAST) state_nxt = DMA_IDLE;
      end
      default: state_nxt = state;
    endcase
    if (start) state_nxt = DMA_START;
  end

endmodule
`default_nettype wire

// File: rtl/sm83_bus_responder.sv
`default_nettype none
// ============================================================================
// sm83_bus_responder : address decode, internal storage and read mux for the
//                      SM83 memory bus, plus the OAM DMA engine
// Revision : 1.0
// ============================================================================
module sm83_bus_responder
  import sm83_pkg::*;
#(
  parameter int WRAM_AW = 13,
  parameter int OAM_LEN = 160
) (
  input  logic                    clk,
  input  logic                    rst,
  sm83_bus_responder_if.slave     bus,
  output logic [7:0]              boot_addr,
  input  logic [7:0]              boot_data,
  output logic [15:0]             cart_addr,
  input  logic [7:0]              cart_rdata,
  output logic [7:0]              cart_wdata,
  output logic                    cart_wen,
  output logic [7:0]              oam_addr,
  output logic [7:0]              oam_wdata,
  output logic                    oam_wen,
  output logic                    dma_active
);

  logic [7:0] wram [2**WRAM_AW];
  logic [7:0] hram [127];

  logic        boot_en;
  logic [7:0]  ie_reg;
  logic [7:0]  dma_reg;

  mem_region_t rd_region, wr_region, dma_region;

  logic        core_wr_ok;
  logic        wram_we, hram_we, ie_we, core_oam_we, boot_off, dma_start;
  logic [WRAM_AW-1:0] wram_raddr;
  logic [7:0]  wram_rdata, hram_rdata;
  logic [7:0]  rd_byte, dma_byte;

  logic [15:0] dma_rd_addr;
  logic        dma_rd_en;
  logic [7:0]  dma_oam_addr, dma_oam_wdata;
  logic        dma_oam_wen;

  assign rd_region  = decode_region(bus.r_addr, boot_en);
  assign wr_region  = decode_region(bus.w_addr, 1'b0);
  assign dma_region = decode_region(dma_rd_addr, 1'b0);

  // Only HRAM/IE stay writable during DMA; an FF46 write always (re)starts it.
  assign core_wr_ok  = bus.w_wen && !dma_active;
  assign cart_wen    = core_wr_ok && (wr_region == CART);
  assign wram_we     = core_wr_ok && (wr_region == WRAM);
  assign core_oam_we = core_wr_ok && (wr_region == OAM);
  assign boot_off    = core_wr_ok && (wr_region == BOOTOFF) && (bus.w_data != 8'h00);
  assign hram_we     = bus.w_wen && (wr_region == HRAM);
  assign ie_we       = bus.w_wen && (wr_region == IE);
  assign dma_start   = bus.w_wen && (wr_region == DMAREG);

  assign boot_addr  = bus.r_addr[7:0];
  assign cart_wdata = bus.w_data;
  assign cart_addr  = cart_wen  ? bus.w_addr :
                      dma_rd_en ? dma_rd_addr : bus.r_addr;

  // Core WRAM reads are masked while DMA runs, so the DMA can own the port.
  assign wram_raddr = dma_rd_en ? dma_rd_addr[WRAM_AW-1:0] : bus.r_addr[WRAM_AW-1:0];
  assign wram_rdata = wram[wram_raddr];
  assign hram_rdata = hram[bus.r_addr[6:0]];

  always_comb begin
    rd_byte = 8'hFF;
    if (!dma_active || rd_region == HRAM || rd_region == IE) begin
      case (rd_region)
        BOOT:    rd_byte = boot_data;
        CART:    rd_byte = cart_rdata;
        WRAM:    rd_byte = wram_rdata;
        DMAREG:  rd_byte = dma_reg;
        HRAM:    rd_byte = hram_rdata;
        IE:      rd_byte = ie_reg;
        default: rd_byte = 8'hFF;
      endcase
    end
  end

  always_comb begin
    dma_byte = 8'hFF;
    case (dma_region)
      CART:    dma_byte = cart_rdata;
      WRAM:    dma_byte = wram_rdata;
      default: dma_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.r_data <= 8'hFF;
      boot_en    <= 1'b1;
      ie_reg     <= 8'h00;
      dma_reg    <= 8'h00;
    end else begin
      bus.r_data <= rd_byte;
      if (boot_off)  boot_en <= 1'b0;
      if (ie_we)     ie_reg  <= bus.w_data;
      if (dma_start) dma_reg <= bus.w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wram_we) wram[bus.w_addr[WRAM_AW-1:0]] <= bus.w_data;
    if (hram_we) hram[bus.w_addr[6:0]]         <= bus.w_data;
  end

  sm83_oam_dma #(
    .OAM_LEN (OAM_LEN)
  ) u_dma (
    .clk       (clk),
    .rst       (rst),
    .start     (dma_start),
    .start_val (bus.w_data),
    .rd_data   (dma_byte),
    .rd_addr   (dma_rd_addr),
    .rd_en     (dma_rd_en),
    .oam_addr  (dma_oam_addr),
    .oam_wdata (dma_oam_wdata),
    .oam_wen   (dma_oam_wen),
    .active    (dma_active)
  );

  assign oam_wen   = dma_oam_wen | core_oam_we;
  assign oam_addr  = dma_oam_wen ? dma_oam_addr  : bus.w_addr[7:0];
  assign oam_wdata = dma_oam_wen ? dma_oam_wdata : bus.w_data;

endmodule
`default_nettype wire

// File: tb/tb_sm83_bus_responder.sv
`default_nettype none
// ============================================================================
// tb_sm83_bus_responder : directed vector table plus DMA sequences
// Revision : 1.0
// ============================================================================
module tb_sm83_bus_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sm83_bus_responder_if bus ();

  logic [7:0]  boot_addr, boot_data, cart_rdata, cart_wdata, oam_addr, oam_wdata;
  logic [15:0] cart_addr;
  logic        cart_wen, oam_wen, dma_active;

  assign boot_data  = boot_addr ^ 8'h31;
  assign cart_rdata = cart_addr[7:0] ^ 8'hC3;

  sm83_bus_responder #(.WRAM_AW(13), .OAM_LEN(160)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .boot_addr  (boot_addr),
    .boot_data  (boot_data),
    .cart_addr  (cart_addr),
    .cart_rdata (cart_rdata),
    .cart_wdata (cart_wdata),
    .cart_wen   (cart_wen),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .oam_wen    (oam_wen),
    .dma_active (dma_active)
  );

  typedef struct {
    logic        we;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [15:0] ra;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt, act_cnt;
  logic [7:0]  shadow [160];
  logic        s_act, s_oam_wen, s_cart_wen;
  logic [7:0]  s_oam_addr, s_oam_wdata, s_cart_wdata;
  logic [15:0] s_cart_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Samples combinational outputs mid-cycle, then steps past the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_act        = dma_active;
    s_oam_wen    = oam_wen;
    s_oam_addr   = oam_addr;
    s_oam_wdata  = oam_wdata;
    s_cart_wen   = cart_wen;
    s_cart_addr  = cart_addr;
    s_cart_wdata = cart_wdata;
    if (oam_wen === 1'b1) begin
      wr_cnt++;
      if (oam_addr < 8'd160) shadow[oam_addr] = oam_wdata;
    end
    if (dma_active === 1'b1) act_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.w_wen  = 1'b1;
    bus.w_addr = a;
    bus.w_data = d;
    tick();
    bus.w_wen  = 1'b0;
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [7:0] exp);
    bus.r_addr = a;
    tick();
    check(name, bus.r_data, exp);
  endtask

  task automatic clear_mon();
    wr_cnt  = 0;
    act_cnt = 0;
    for (int i = 0; i < 160; i++) shadow[i] = 8'h00;
  endtask

  task automatic check_shadow(input string name, input logic [7:0] key);
    int bad = 0;
    logic [7:0] e;
    for (int i = 0; i < 160; i++) begin
      e = 8'(i) ^ key;
      if (shadow[i] !== e) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    bus.r_addr = 16'h0000;
    bus.w_addr = 16'h0000;
    bus.w_data = 8'h00;
    bus.w_wen  = 1'b0;
    clear_mon();
    rst = 1'b1;
    idle(2);
    check("reset r_data", bus.r_data, 8'hFF);
    check("reset dma_active", s_act, 1'b0);
    check("reset oam_wen", s_oam_wen, 1'b0);
    check("reset cart_wen", s_cart_wen, 1'b0);
    rst = 1'b0;

    // Low-page write goes to the cartridge even with the boot ROM mapped.
    bus.r_addr = 16'h0000;
    wr(16'h0010, 8'h99);
    check("cart_wen low page", s_cart_wen, 1'b1);
    check("cart_addr on write", s_cart_addr, 16'h0010);
    check("cart_wdata", s_cart_wdata, 8'h99);
    check("boot read", bus.r_data, 8'h31);
    wr(16'hFE10, 8'h44);
    check("core oam_wen", s_oam_wen, 1'b1);
    check("core oam_addr", s_oam_addr, 8'h10);
    check("core oam_wdata", s_oam_wdata, 8'h44);

    vecs.push_back('{1'b0, 16'h0000, 8'h00, 16'h0000, 1'b1, 8'h31});
    vecs.push_back('{1'b0, 16'h0000, 8'h00, 16'h0005, 1'b1, 8'h34});
    vecs.push_back('{1'b1, 16'hFF50, 8'h01, 16'h0100, 1'b1, 8'hC3});
    vecs.push_back('{1'b0, 16'h0000, 8'h00, 16'h0000, 1'b1, 8'hC3});
    vecs.push_back('{1'b1, 16'hC123, 8'h5A, 16'h8000, 1'b1, 8'hFF});
    vecs.push_back('{1'b0, 16'h0000, 8'h00, 16'hE123, 1'b1, 8'h5A});
    vecs.push_back('{1'b1, 16'hFFFF, 8'h1F, 16'hFFFF, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 16'h0000, 8'h00, 16'hFFFF, 1'b1, 8'h1F});
    vecs.push_back('{1'b1, 16'hFF80, 8'h77, 16'hFF46, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 16'h0000, 8'h00, 16'hFF80, 1'b1, 8'h77});
    vecs.push_back('{1'b1, 16'hDDFF, 8'hAB, 16'hFE00, 1'b1, 8'hFF});
    vecs.push_back('{1'b0, 16'h0000, 8'h00, 16'hFDFF, 1'b1, 8'hAB});
    vecs.push_back('{1'b0, 16'h0000, 8'h00, 16'hA005, 1'b1, 8'hC6});
    vecs.push_back('{1'b0, 16'h0000, 8'h00, 16'hFF50, 1'b1, 8'hFF});
    vecs.push_back('{1'b1, 16'hFF50, 8'h00, 16'hC123, 1'b1, 8'h5A});
    vecs.push_back('{1'b0, 16'h0000, 8'h00, 16'h9FFF, 1'b1, 8'hFF});
    vecs.push_back('{1'b0, 16'h0000, 8'h00, 16'hFEA0, 1'b1, 8'hFF});

    foreach (vecs[i]) begin
      bus.w_wen  = vecs[i].we;
      bus.w_addr = vecs[i].wa;
      bus.w_data = vecs[i].wd;
      bus.r_addr = vecs[i].ra;
      tick();
      if (vecs[i].chk) check($sformatf("vec%0d r_data", i), bus.r_data, vecs[i].exp);
    end
    bus.w_wen = 1'b0;

    // DMA from C000 with core traffic during the transfer.
    for (int i = 0; i < 160; i++) wr(16'hC000 + 16'(i), 8'(i) ^ 8'hA5);
    clear_mon();
    bus.r_addr = 16'h0000;
    wr(16'hFF46, 8'hC0);
    for (int k = 0; k < 180; k++) begin
      if (k == 40) bus.r_addr = 16'hC000;
      if (k == 41) bus.r_addr = 16'hFF80;
      if (k == 50) begin bus.w_wen = 1'b1; bus.w_addr = 16'h2000; bus.w_data = 8'h12; end
      if (k == 51) begin bus.w_wen = 1'b1; bus.w_addr = 16'hC000; bus.w_data = 8'h00; end
      tick();
      bus.w_wen = 1'b0;
      if (k == 0)  check("dma_active rises", s_act, 1'b1);
      if (k == 40) check("core WRAM read in dma", bus.r_data, 8'hFF);
      if (k == 41) check("core HRAM read in dma", bus.r_data, 8'h77);
      if (k == 50) check("cart write dropped in dma", s_cart_wen, 1'b0);
    end
    check("dma_active cycles", act_cnt, 162);
    check("dma oam writes", wr_cnt, 160);
    check("dma ends idle", s_act, 1'b0);
    check_shadow("dma C0 data", 8'hA5);
    rd("WRAM write dropped in dma", 16'hC000, 8'hA5);
    rd("FF46 readback", 16'hFF46, 8'hC0);

    // E0 aliases to C0.
    clear_mon();
    wr(16'hFF46, 8'hE0);
    idle(175);
    check("dma E0 writes", wr_cnt, 160);
    check_shadow("dma E0 data", 8'hA5);
    rd("FF46 readback E0", 16'hFF46, 8'hE0);

    // Restart mid-transfer onto page C1.
    for (int i = 0; i < 160; i++) wr(16'hC100 + 16'(i), 8'(i) ^ 8'h5C);
    clear_mon();
    wr(16'hFF46, 8'hC0);
    idle(60);
    wr(16'hFF46, 8'hC1);
    idle(170);
    check("restart oam writes", wr_cnt, 219);
    check_shadow("restart C1 data", 8'h5C);

    // Reset at XFER cnt=50 aborts immediately.
    wr(16'hFF46, 8'hC0);
    idle(51);
    rst = 1'b1;
    tick();
    check("pre-abort oam_wen", s_oam_wen, 1'b1);
    check("pre-abort oam_addr", s_oam_addr, 8'd49);
    check("r_data after reset", bus.r_data, 8'hFF);
    rst = 1'b0;
    bus.r_addr = 16'h0000;
    tick();
    check("abort dma_active", s_act, 1'b0);
    check("abort oam_wen", s_oam_wen, 1'b0);
    check("boot_en after reset", bus.r_data, 8'h31);
    rd("FF46 after reset", 16'hFF46, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
